// File: rtl/syn_fgyrus_butterfly.sv
// Radix-2 DIT butterfly for the Fgyrus FFT engine.
// Accepts (A, B, W) at most every other cycle and emits A+B*W then A-B*W
// as two consecutive complex words on one output port.
// Pipeline: input regs -> scaled product regs -> result/output regs.
module syn_fgyrus_butterfly #(
   parameter int SAMPLE_W = 32,
   parameter int TWDL_W   = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_a_real,
   input  logic [SAMPLE_W-1:0] sample_a_im,
   input  logic [SAMPLE_W-1:0] sample_b_real,
   input  logic [SAMPLE_W-1:0] sample_b_im,
   input  logic [TWDL_W-1:0]   twdl_real,
   input  logic [TWDL_W-1:0]   twdl_im,
   input  logic                samples_rdy,
   output logic [SAMPLE_W-1:0] data_real,
   output logic [SAMPLE_W-1:0] data_im,
   output logic                data_rdy
);

   // Full-precision product width and twiddle fraction bits.
   localparam int PW = SAMPLE_W + TWDL_W + 1;
   localparam int SH = TWDL_W - 2;

   logic                in_vld;
   logic [SAMPLE_W-1:0] a_real_q, a_im_q, b_real_q, b_im_q;
   logic [TWDL_W-1:0]   w_real_q, w_im_q;

   logic                prod_vld;
   logic [SAMPLE_W-1:0] a_real_p, a_im_p, p_real_q, p_im_q;

   logic [SAMPLE_W-1:0] y_real_q, y_im_q;
   logic                y_pend;

   logic                accept;
   logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
   logic signed [PW-1:0] pr_full, pi_full;
   logic [SAMPLE_W-1:0]  x_real, x_im, y_real, y_im;
   logic                 unused_prod_bits;

   // An accept on the previous edge blocks this one: one pair per 2 cycles.
   assign accept = samples_rdy & ~in_vld;

   // Input stage: capture the operands on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_vld <= 1'b0;
      end else begin
         in_vld <= accept;
         if (accept) begin
            a_real_q <= sample_a_real;
            a_im_q   <= sample_a_im;
            b_real_q <= sample_b_real;
            b_im_q   <= sample_b_im;
            w_real_q <= twdl_real;
            w_im_q   <= twdl_im;
         end
      end
   end

   assign br_x = {{(PW-SAMPLE_W){b_real_q[SAMPLE_W-1]}}, b_real_q};
   assign bi_x = {{(PW-SAMPLE_W){b_im_q[SAMPLE_W-1]}}, b_im_q};
   assign wr_x = {{(PW-TWDL_W){w_real_q[TWDL_W-1]}}, w_real_q};
   assign wi_x = {{(PW-TWDL_W){w_im_q[TWDL_W-1]}}, w_im_q};

   // True products fit in PW bits, so the PW-wide multiply is exact.
   assign pr_full = br_x * wr_x - bi_x * wi_x;
   assign pi_full = br_x * wi_x + bi_x * wr_x;

   // Fraction bits and bits above the kept window are intentionally dropped;
   // selecting [SH +: SAMPLE_W] equals an arithmetic shift then truncation.
   assign unused_prod_bits = ^{pr_full[PW-1:SH+SAMPLE_W], pr_full[SH-1:0],
                               pi_full[PW-1:SH+SAMPLE_W], pi_full[SH-1:0]};

   // Product stage: register the scaled product alongside A.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_vld <= 1'b0;
      end else begin
         prod_vld <= in_vld;
         if (in_vld) begin
            a_real_p <= a_real_q;
            a_im_p   <= a_im_q;
            p_real_q <= pr_full[SH +: SAMPLE_W];
            p_im_q   <= pi_full[SH +: SAMPLE_W];
         end
      end
   end

   // Sum and difference wrap modulo 2^SAMPLE_W.
   assign x_real = a_real_p + p_real_q;
   assign x_im   = a_im_p + p_im_q;
   assign y_real = a_real_p - p_real_q;
   assign y_im   = a_im_p - p_im_q;

   // Result stage: drive X immediately, park Y for the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_rdy  <= 1'b0;
         data_real <= '0;
         data_im   <= '0;
         y_pend    <= 1'b0;
      end else if (prod_vld) begin
         data_rdy  <= 1'b1;
         data_real <= x_real;
         data_im   <= x_im;
         y_real_q  <= y_real;
         y_im_q    <= y_im;
         y_pend    <= 1'b1;
      end else if (y_pend) begin
         data_rdy  <= 1'b1;
         data_real <= y_real_q;
         data_im   <= y_im_q;
         y_pend    <= 1'b0;
      end else begin
         data_rdy  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_syn_fgyrus_butterfly.sv
// Scoreboard bench for syn_fgyrus_butterfly.
module tb_syn_fgyrus_butterfly;

   localparam int SW = 32;
   localparam int TW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] a_r, a_i, b_r, b_i;
   logic [TW-1:0] w_r, w_i;
   logic          samples_rdy;
   logic [SW-1:0] data_real, data_im;
   logic          data_rdy;

   typedef struct {
      logic [SW-1:0] r;
      logic [SW-1:0] i;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   bit            last_acc = 1'b0;
   bit            rst_hit = 1'b0;
   bit            armed = 1'b0;
   logic [SW-1:0] last_r = '0, last_i = '0;

   syn_fgyrus_butterfly #(.SAMPLE_W(SW), .TWDL_W(TW)) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_a_real (a_r),
      .sample_a_im   (a_i),
      .sample_b_real (b_r),
      .sample_b_im   (b_i),
      .twdl_real     (w_r),
      .twdl_im       (w_i),
      .samples_rdy   (samples_rdy),
      .data_real     (data_real),
      .data_im       (data_im),
      .data_rdy      (data_rdy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         rst_hit = 1'b1;
         armed   = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [127:0] model(input logic [SW-1:0] ar, ai, br, bi,
                                          input logic [TW-1:0] wr, wi);
      longint        pr, pi;
      logic [SW-1:0] p_r, p_i;
      pr = longint'($signed(br)) * longint'($signed(wr))
         - longint'($signed(bi)) * longint'($signed(wi));
      pi = longint'($signed(br)) * longint'($signed(wi))
         + longint'($signed(bi)) * longint'($signed(wr));
      pr = pr >>> (TW - 2);
      pi = pi >>> (TW - 2);
      p_r = pr[SW-1:0];
      p_i = pi[SW-1:0];
      return {ar + p_r, ai + p_i, ar - p_r, ai - p_i};
   endfunction

   // Output monitor: pop expected words, otherwise outputs must hold.
   always @(negedge clk) begin
      exp_t e;
      if (armed) begin
         if (rst_hit) begin
            last_r  = '0;
            last_i  = '0;
            rst_hit = 1'b0;
         end
         if (data_rdy === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_rdy", {63'd0, data_rdy}, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("word", {data_real, data_im}, {e.r, e.i});
               chk("latency", 64'(cyc), 64'(e.cyc));
               last_r = data_real;
               last_i = data_im;
            end
         end else begin
            chk("hold", {data_real, data_im}, {last_r, last_i});
         end
      end
   end

   // One cycle of stimulus; pushes expectations when the pair will be accepted.
   task automatic drive(input bit rdy, input logic [SW-1:0] ar, ai, br, bi,
                        input logic [TW-1:0] wr, wi, input bit given,
                        input logic [SW-1:0] xr, xi, yr, yi);
      logic [127:0] m;
      a_r = ar; a_i = ai; b_r = br; b_i = bi; w_r = wr; w_i = wi;
      samples_rdy = rdy;
      if (rdy && !last_acc) begin
         if (given) m = {xr, xi, yr, yi};
         else       m = model(ar, ai, br, bi, wr, wi);
         sb.push_back('{m[127:96], m[95:64], cyc + 3});
         sb.push_back('{m[63:32], m[31:0], cyc + 4});
         last_acc = 1'b1;
      end else begin
         last_acc = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic drive_rand(input bit rdy);
      drive(rdy, $urandom, $urandom, $urandom, $urandom, TW'($urandom), TW'($urandom),
            1'b0, '0, '0, '0, '0);
   endtask

   task automatic idle(input int n);
      samples_rdy = 1'b0;
      a_r = $urandom; b_r = $urandom; w_r = TW'($urandom);
      last_acc = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      samples_rdy = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      samples_rdy = 1'b0;
      sb.delete();
      last_acc = 1'b0;
      chk("rst_rdy", {63'd0, data_rdy}, 64'd0);
      chk("rst_data", {data_real, data_im}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      samples_rdy = 1'b0;
      a_r = '0; a_i = '0; b_r = '0; b_i = '0; w_r = '0; w_i = '0;
      repeat (2) @(negedge clk);
      do_reset();
      idle(2);

      // unity twiddle
      drive(1, 32'd100, 32'd50, 32'd20, -32'sd10, 10'd256, 10'd0, 1,
            32'd120, 32'd40, 32'd80, 32'd60);
      idle(4);
      // -j twiddle
      drive(1, 32'd100, 32'd50, 32'd20, -32'sd10, 10'd0, 10'h300, 1,
            32'd90, 32'd30, 32'd110, 32'd70);
      idle(4);
      // truncation toward -inf
      drive(1, 32'd0, 32'd0, 32'd3, 32'd0, 10'd128, 10'd0, 1,
            32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0);
      idle(4);
      drive(1, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd0, 10'd128, 10'd0, 1,
            32'hFFFF_FFFE, 32'd0, 32'd2, 32'd0);
      idle(4);
      // wrap-around
      drive(1, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 10'd256, 10'd0, 1,
            32'h8000_0000, 32'd0, 32'h7FFF_FFFE, 32'd0);
      idle(4);

      // four back-to-back: only P0 and P2 accepted
      for (int k = 0; k < 4; k++) drive_rand(1'b1);
      idle(6);

      // reset on the edge after X appears
      drive(1, 32'd100, 32'd50, 32'd20, -32'sd10, 10'd256, 10'd0, 1,
            32'd120, 32'd40, 32'd80, 32'd60);
      idle(2);
      do_reset();
      idle(4);
      drive(1, 32'd100, 32'd50, 32'd20, -32'sd10, 10'd0, 10'h300, 1,
            32'd90, 32'd30, 32'd110, 32'd70);
      idle(5);

      // random traffic with random gaps
      for (int k = 0; k < 40; k++) drive_rand(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      idle(6);

      chk("drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
